// File: rtl/arbitro_comparador.sv
// Round-robin arbiter that time-shares one external comparator among
// numReq requesters. Each transaction runs ESPERA -> COMPARA -> RESPONDE:
// grant and latch operands, capture the comparator result, then deliver it
// to the owning requester with a one-cycle respValid pulse.
module arbitro_comparador #(
    parameter int unsigned bitsEntry = 4,
    parameter int unsigned numReq    = 4,
    parameter int unsigned bitsOut   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [numReq-1:0]             reqValid,
    input  logic [numReq*bitsEntry-1:0]   reqA,
    input  logic [numReq*bitsEntry-1:0]   reqB,
    output logic [numReq-1:0]             reqReady,
    output logic [bitsEntry-1:0]          compA,
    output logic [bitsEntry-1:0]          compB,
    input  logic [bitsOut-1:0]            compSalida,
    output logic [numReq-1:0]             respValid,
    output logic [bitsOut-1:0]            respSalida,
    output logic                          errorOneHot,
    output logic [7:0]                    cuenta
);

    localparam int unsigned idxW = (numReq > 1) ? $clog2(numReq) : 1;

    typedef enum logic [1:0] {
        ESPERA,
        COMPARA,
        RESPONDE
    } estadoT;

    estadoT               estado;
    logic [idxW-1:0]      ptr;
    logic [idxW-1:0]      idxReg;
    logic                 grantFound;
    logic [idxW-1:0]      grantIdx;
    int unsigned          scanPos;
    logic [idxW-1:0]      scanIdx;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        scanPos    = 0;
        scanIdx    = '0;
        for (int unsigned k = 0; k < numReq; k++) begin
            scanPos = 32'(ptr) + k;
            if (scanPos >= numReq) begin
                scanPos = scanPos - numReq;
            end
            scanIdx = idxW'(scanPos);
            if (!grantFound && reqValid[scanIdx]) begin
                grantFound = 1'b1;
                grantIdx   = scanIdx;
            end
        end
    end

    // Accept pulse is decoded from the grant in ESPERA so it lands in the
    // same cycle the request is sampled; masked while reset is held.
    always_comb begin
        reqReady = '0;
        if (rst_n && (estado == ESPERA) && grantFound) begin
            reqReady[grantIdx] = 1'b1;
        end
    end

    // Transaction FSM with operand latches, result capture and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= ESPERA;
            ptr         <= '0;
            idxReg      <= '0;
            compA       <= '0;
            compB       <= '0;
            respValid   <= '0;
            respSalida  <= '0;
            errorOneHot <= 1'b0;
            cuenta      <= '0;
        end else begin
            case (estado)
                ESPERA: begin
                    respValid <= '0;
                    if (grantFound) begin
                        compA  <= reqA[grantIdx*bitsEntry +: bitsEntry];
                        compB  <= reqB[grantIdx*bitsEntry +: bitsEntry];
                        idxReg <= grantIdx;
                        estado <= COMPARA;
                    end
                end
                COMPARA: begin
                    respSalida <= compSalida;
                    if (!$onehot(compSalida)) begin
                        errorOneHot <= 1'b1;
                    end
                    respValid         <= '0;
                    respValid[idxReg] <= 1'b1;
                    estado            <= RESPONDE;
                end
                RESPONDE: begin
                    respValid <= '0;
                    if (cuenta != 8'hFF) begin
                        cuenta <= cuenta + 8'd1;
                    end
                    if (32'(idxReg) == numReq - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= idxReg + 1'b1;
                    end
                    estado <= ESPERA;
                end
                default: begin
                    respValid <= '0;
                    estado    <= ESPERA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_comparador.sv
// Testbench for arbitro_comparador: the bench plays the shared comparator and
// all requesters, and predicts grants, results and statistics from a
// transaction-level model (pending set, round-robin pointer, counters).
module tb_arbitro_comparador;

    localparam int unsigned BE = 4;
    localparam int unsigned NR = 4;
    localparam int unsigned BO = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NR-1:0]      reqValid = '0;
    logic [NR*BE-1:0]   reqA = '0;
    logic [NR*BE-1:0]   reqB = '0;
    logic [NR-1:0]      reqReady;
    logic [BE-1:0]      compA;
    logic [BE-1:0]      compB;
    logic [BO-1:0]      compSalida;
    logic [NR-1:0]      respValid;
    logic [BO-1:0]      respSalida;
    logic               errorOneHot;
    logic [7:0]         cuenta;

    int vectors = 0;
    int miscompares = 0;
    bit faulty = 1'b0;

    bit          pendV [NR];
    logic [BE-1:0] pendA [NR];
    logic [BE-1:0] pendB [NR];
    int unsigned mPtr = 0;
    int unsigned mCount = 0;
    bit          mErr = 1'b0;

    arbitro_comparador #(.bitsEntry(BE), .numReq(NR), .bitsOut(BO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reqValid(reqValid),
        .reqA(reqA),
        .reqB(reqB),
        .reqReady(reqReady),
        .compA(compA),
        .compB(compB),
        .compSalida(compSalida),
        .respValid(respValid),
        .respSalida(respSalida),
        .errorOneHot(errorOneHot),
        .cuenta(cuenta)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] cmpRef(input logic [BE-1:0] a, input logic [BE-1:0] b);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return 3'b001;
    endfunction

    // Shared comparator, optionally broken to return a non-one-hot code.
    assign compSalida = faulty ? 3'b110 : cmpRef(compA, compB);

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int expGrant();
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (int'(mPtr) + k) % NR;
            if (pendV[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            reqValid[i]        = pendV[i];
            reqA[i*BE +: BE]   = pendA[i];
            reqB[i*BE +: BE]   = pendB[i];
        end
    endtask

    task automatic newRequest(input int i);
        pendV[i] = 1'b1;
        pendA[i] = BE'($urandom);
        pendB[i] = ($urandom_range(3, 0) == 0) ? pendA[i] : BE'($urandom);
    endtask

    // Reset pulse: outputs must clear at once; released on a falling edge.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("rstReqReady", reqReady, 0);
        check("rstRespValid", respValid, 0);
        check("rstCompA", compA, 0);
        check("rstCompB", compB, 0);
        check("rstRespSalida", respSalida, 0);
        check("rstError", errorOneHot, 0);
        check("rstCuenta", cuenta, 0);
        mPtr = 0;
        mCount = 0;
        mErr = 1'b0;
        @(negedge clk);
        check("rstHoldRespValid", respValid, 0);
        check("rstHoldReqReady", reqReady, 0);
        rst_n = 1'b1;
    endtask

    // One full transaction starting at a falling edge in ESPERA.
    // mode 0: accepted requester drops; 1: re-requests same operands;
    // 2: random new requests from idle requesters.
    task automatic runTxn(input int mode);
        int g;
        logic [2:0] expRes;
        drive();
        #1;
        g = expGrant();
        if (g < 0) return;
        check("reqReady", reqReady, oh(g));
        expRes = faulty ? 3'b110 : cmpRef(pendA[g], pendB[g]);
        @(negedge clk);
        check("compA", compA, pendA[g]);
        check("compB", compB, pendB[g]);
        check("readyInCompara", reqReady, 0);
        check("respInCompara", respValid, 0);
        pendV[g] = 1'b0;
        if (mode == 1) begin
            pendV[g] = 1'b1;
        end else if (mode == 2) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!pendV[i] && ($urandom_range(1, 0) == 1)) newRequest(i);
                if (pendV[i]) any = 1'b1;
            end
            if (!any) newRequest(int'($urandom_range(NR - 1, 0)));
        end
        drive();
        @(negedge clk);
        check("respValid", respValid, oh(g));
        check("respSalida", respSalida, expRes);
        check("readyInResponde", reqReady, 0);
        mPtr = (g + 1) % NR;
        if (mCount < 255) mCount++;
        if ($countones(expRes) != 1) mErr = 1'b1;
        @(negedge clk);
        check("respAfter", respValid, 0);
        check("cuenta", cuenta, mCount);
        check("errorOneHot", errorOneHot, mErr);
    endtask

    task automatic clearPend();
        for (int i = 0; i < NR; i++) begin
            pendV[i] = 1'b0;
            pendA[i] = '0;
            pendB[i] = '0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clearPend();
        drive();
        @(negedge clk);
        doReset();

        // Idle: no requests means no accept pulses.
        repeat (3) begin
            @(negedge clk);
            check("idleReqReady", reqReady, 0);
            check("idleRespValid", respValid, 0);
        end

        // Single request on requester 0: 9 vs 4.
        pendV[0] = 1'b1; pendA[0] = 4'd9; pendB[0] = 4'd4;
        runTxn(0);

        // All requesters continuously valid with equal operands.
        for (int i = 0; i < NR; i++) begin
            pendV[i] = 1'b1; pendA[i] = 4'd5; pendB[i] = 4'd5;
        end
        drive();
        doReset();
        repeat (5) runTxn(1);

        // Pointer wrap: grant 2, then requests on 0 and 3.
        clearPend();
        drive();
        doReset();
        pendV[2] = 1'b1; pendA[2] = 4'd1; pendB[2] = 4'd14;
        runTxn(0);
        pendV[0] = 1'b1; pendA[0] = 4'd7; pendB[0] = 4'd2;
        pendV[3] = 1'b1; pendA[3] = 4'd3; pendB[3] = 4'd3;
        runTxn(0);
        runTxn(0);

        // Faulty comparator, then good traffic: error must stay sticky.
        faulty = 1'b1;
        pendV[1] = 1'b1; pendA[1] = 4'd6; pendB[1] = 4'd8;
        runTxn(0);
        faulty = 1'b0;
        newRequest(2);
        repeat (4) runTxn(2);

        // Reset during COMPARA aborts the transaction.
        for (int i = 0; i < NR; i++) newRequest(i);
        mPtr = mPtr;
        drive();
        #1;
        check("abortGrant", reqReady, oh(expGrant()));
        @(negedge clk);
        doReset();
        runTxn(2);

        // Back-to-back random traffic until the counter saturates.
        drive();
        doReset();
        repeat (260) runTxn(2);
        check("cuentaSat", cuenta, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
